rob: RTL and testbench

//  Reorder buffer: the receiving end of the RS/SLB result broadcast and the source of commit broadcasts.

---
 rtl/rob.sv | 233 +++++++++++++++++++++++
 tb/tb_rob.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob -- reorder buffer
//
// Allocates one entry per cycle at issue and collects out-of-order results
// from the reservation stations (tag b2) and the store/load buffer (tag b4).
// It retires at most one entry per cycle in program order, and broadcasts the
// committed (tag, value) pair to RS/SLB and to the register file. At commit
// it detects branch mispredicts and JALR redirects, then flushes the machine.
//
// Ports
//   clk, rst (async, active low), rdy (0 = freeze)
//   insqueue_to_ROB_needchange + ROB_s_*_in     : allocation request/fields
//   ROB_alloc_pos, ROB_full                      : tag of next alloc, full flag
//   RS_to_ROB_needchange(2), b2, ROB_s_*_b2_     : RS result writeback
//   SLB_to_ROB_needchange, b4, SLB_to_ROB_value  : SLB result writeback
//   ROB_to_RS_needchange, b3, ROB_to_RS_value_b3 : commit broadcast (pulse)
//   ROB_to_reg_needchange, ROB_to_reg_rd         : register write (pulse)
//   ROB_to_SLB_storecommit                       : store commit (pulse)
//   Clear_flag, clear_pc                         : flush pulse + redirect pc
// -----------------------------------------------------------------------------
module rob #(
  parameter int ROB_DEPTH = 32,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             insqueue_to_ROB_needchange,
  input  logic [1:0]       ROB_s_kind_in,
  input  logic [4:0]       ROB_s_dest_in,
  input  logic [31:0]      ROB_s_pc_in,
  input  logic [31:0]      ROB_s_jumppc_in,
  input  logic             ROB_s_predtaken_in,
  output logic [IDX_W-1:0] ROB_alloc_pos,
  output logic             ROB_full,
  input  logic             RS_to_ROB_needchange,
  input  logic             RS_to_ROB_needchange2,
  input  logic [IDX_W-1:0] b2,
  input  logic [31:0]      ROB_s_value_b2_,
  input  logic             ROB_s_ready_b2_,
  input  logic [31:0]      ROB_s_jumppc_b2_,
  input  logic             SLB_to_ROB_needchange,
  input  logic [IDX_W-1:0] b4,
  input  logic [31:0]      SLB_to_ROB_value,
  output logic             ROB_to_RS_needchange,
  output logic [IDX_W-1:0] b3,
  output logic [31:0]      ROB_to_RS_value_b3,
  output logic             ROB_to_reg_needchange,
  output logic [4:0]       ROB_to_reg_rd,
  output logic             ROB_to_SLB_storecommit,
  output logic             Clear_flag,
  output logic [31:0]      clear_pc
);

  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_JALR   = 2'd2;
  localparam logic [1:0] KIND_STORE  = 2'd3;

  // Returns {redirect, redirect_pc} for the entry being committed.
  function automatic logic [32:0] redirect_of(
    input logic [1:0]  kind,
    input logic        taken,
    input logic        pred,
    input logic [31:0] pc,
    input logic [31:0] target
  );
    logic [32:0] r;
    r = 33'd0;
    case (kind)
      KIND_BRANCH: begin
        if (taken != pred) begin
          r = {1'b1, (taken ? target : pc + 32'd4)};
        end else begin
          r = 33'd0;
        end
      end
      KIND_JALR: r = {1'b1, target};
      default:   r = 33'd0;
    endcase
    return r;
  endfunction

  // Pointers and occupancy.
  logic [IDX_W-1:0] head_r;
  logic [IDX_W-1:0] tail_r;
  logic [IDX_W:0]   count_r;

  // Per-entry control state.
  logic [ROB_DEPTH-1:0] busy_r;
  logic [ROB_DEPTH-1:0] ready_r;

  // Per-entry payload.
  logic [1:0]  kind_r   [ROB_DEPTH];
  logic [4:0]  dest_r   [ROB_DEPTH];
  logic [31:0] pc_r     [ROB_DEPTH];
  logic [31:0] jumppc_r [ROB_DEPTH];
  logic        pred_r   [ROB_DEPTH];
  logic [31:0] value_r  [ROB_DEPTH];

  logic        commit_s;
  logic        commit_fire_s;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic        flush_s;
  logic        alloc_fire_s;
  logic        rs_wr_s;
  logic        slb_wr_s;
  logic        writes_rd_s;

  assign ROB_alloc_pos = tail_r;
  assign ROB_full      = (count_r == (IDX_W+1)'(ROB_DEPTH));

  // Commit, flush, allocation and writeback qualification for this cycle.
  always_comb begin
    commit_s      = busy_r[head_r] && ready_r[head_r];
    {redirect_s, redirect_pc_s} = redirect_of(kind_r[head_r], value_r[head_r][0],
                                              pred_r[head_r], pc_r[head_r],
                                              jumppc_r[head_r]);
    commit_fire_s = rdy && commit_s;
    flush_s       = commit_fire_s && redirect_s;
    // A flushing commit empties the buffer, so a same-cycle alloc is lost.
    alloc_fire_s  = rdy && insqueue_to_ROB_needchange && !ROB_full && !flush_s;
    // A result aimed at the slot being allocated right now belongs to a stale
    // producer; the new allocation takes precedence.
    rs_wr_s       = rdy && RS_to_ROB_needchange && busy_r[b2] &&
                    !(alloc_fire_s && (b2 == tail_r));
    slb_wr_s      = rdy && SLB_to_ROB_needchange && busy_r[b4] &&
                    !(alloc_fire_s && (b4 == tail_r));
    writes_rd_s   = ((kind_r[head_r] == KIND_ALU) || (kind_r[head_r] == KIND_JALR)) &&
                    (dest_r[head_r] != 5'd0);
  end

  // Head/tail pointers and entry count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (alloc_fire_s) begin
        tail_r <= tail_r + IDX_W'(1);
      end
      if (commit_fire_s) begin
        head_r <= head_r + IDX_W'(1);
      end
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_r <= count_r + (IDX_W+1)'(1);
        2'b01:   count_r <= count_r - (IDX_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Busy/ready flags: writeback sets ready, commit/flush clears, alloc reopens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r  <= '0;
      ready_r <= '0;
    end else begin
      if (rs_wr_s) begin
        ready_r[b2] <= ROB_s_ready_b2_;
      end
      if (slb_wr_s) begin
        ready_r[b4] <= 1'b1;
      end
      if (flush_s) begin
        busy_r  <= '0;
        ready_r <= '0;
      end else if (commit_fire_s) begin
        busy_r[head_r]  <= 1'b0;
        ready_r[head_r] <= 1'b0;
      end
      if (alloc_fire_s) begin
        busy_r[tail_r]  <= 1'b1;
        ready_r[tail_r] <= 1'b0;
      end
    end
  end

  // Payload storage; not reset because busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rs_wr_s) begin
      value_r[b2] <= ROB_s_value_b2_;
      if (RS_to_ROB_needchange2) begin
        jumppc_r[b2] <= ROB_s_jumppc_b2_;
      end
    end
    if (slb_wr_s) begin
      value_r[b4] <= SLB_to_ROB_value;
    end
    if (alloc_fire_s) begin
      kind_r[tail_r]   <= ROB_s_kind_in;
      dest_r[tail_r]   <= ROB_s_dest_in;
      pc_r[tail_r]     <= ROB_s_pc_in;
      jumppc_r[tail_r] <= ROB_s_jumppc_in;
      pred_r[tail_r]   <= ROB_s_predtaken_in;
    end
  end

  // Registered commit broadcast; pulses last exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ROB_to_RS_needchange   <= 1'b0;
      b3                     <= '0;
      ROB_to_RS_value_b3     <= 32'd0;
      ROB_to_reg_needchange  <= 1'b0;
      ROB_to_reg_rd          <= 5'd0;
      ROB_to_SLB_storecommit <= 1'b0;
      Clear_flag             <= 1'b0;
      clear_pc               <= 32'd0;
    end else if (commit_fire_s) begin
      ROB_to_RS_needchange   <= 1'b1;
      b3                     <= head_r;
      ROB_to_RS_value_b3     <= value_r[head_r];
      ROB_to_reg_needchange  <= writes_rd_s;
      ROB_to_reg_rd          <= dest_r[head_r];
      ROB_to_SLB_storecommit <= (kind_r[head_r] == KIND_STORE);
      Clear_flag             <= redirect_s;
      clear_pc               <= redirect_pc_s;
    end else begin
      ROB_to_RS_needchange   <= 1'b0;
      ROB_to_reg_needchange  <= 1'b0;
      ROB_to_SLB_storecommit <= 1'b0;
      Clear_flag             <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob.sv
module tb_rob;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        insqueue_to_ROB_needchange;
  logic [1:0]  ROB_s_kind_in;
  logic [4:0]  ROB_s_dest_in;
  logic [31:0] ROB_s_pc_in;
  logic [31:0] ROB_s_jumppc_in;
  logic        ROB_s_predtaken_in;
  logic [4:0]  ROB_alloc_pos;
  logic        ROB_full;
  logic        RS_to_ROB_needchange;
  logic        RS_to_ROB_needchange2;
  logic [4:0]  b2;
  logic [31:0] ROB_s_value_b2_;
  logic        ROB_s_ready_b2_;
  logic [31:0] ROB_s_jumppc_b2_;
  logic        SLB_to_ROB_needchange;
  logic [4:0]  b4;
  logic [31:0] SLB_to_ROB_value;
  logic        ROB_to_RS_needchange;
  logic [4:0]  b3;
  logic [31:0] ROB_to_RS_value_b3;
  logic        ROB_to_reg_needchange;
  logic [4:0]  ROB_to_reg_rd;
  logic        ROB_to_SLB_storecommit;
  logic        Clear_flag;
  logic [31:0] clear_pc;

  rob #(.ROB_DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .insqueue_to_ROB_needchange(insqueue_to_ROB_needchange),
    .ROB_s_kind_in(ROB_s_kind_in), .ROB_s_dest_in(ROB_s_dest_in),
    .ROB_s_pc_in(ROB_s_pc_in), .ROB_s_jumppc_in(ROB_s_jumppc_in),
    .ROB_s_predtaken_in(ROB_s_predtaken_in),
    .ROB_alloc_pos(ROB_alloc_pos), .ROB_full(ROB_full),
    .RS_to_ROB_needchange(RS_to_ROB_needchange),
    .RS_to_ROB_needchange2(RS_to_ROB_needchange2),
    .b2(b2), .ROB_s_value_b2_(ROB_s_value_b2_), .ROB_s_ready_b2_(ROB_s_ready_b2_),
    .ROB_s_jumppc_b2_(ROB_s_jumppc_b2_),
    .SLB_to_ROB_needchange(SLB_to_ROB_needchange), .b4(b4),
    .SLB_to_ROB_value(SLB_to_ROB_value),
    .ROB_to_RS_needchange(ROB_to_RS_needchange), .b3(b3),
    .ROB_to_RS_value_b3(ROB_to_RS_value_b3),
    .ROB_to_reg_needchange(ROB_to_reg_needchange), .ROB_to_reg_rd(ROB_to_reg_rd),
    .ROB_to_SLB_storecommit(ROB_to_SLB_storecommit),
    .Clear_flag(Clear_flag), .clear_pc(clear_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model: program-ordered queue of entries -------
  typedef struct {
    int          tag;
    logic [1:0]  kind;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] jpc;
    logic        pred;
    logic [31:0] value;
    logic        ready;
  } ment_t;

  ment_t m_q[$];
  int    m_head = 0;

  task automatic model_reset();
    m_q.delete();
    m_head = 0;
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic tick();
    ment_t ce;
    bit c, redir, full_pre, e_reg, e_st;
    logic [31:0] cpc;
    c = 0; redir = 0; cpc = 32'd0; e_reg = 0; e_st = 0;
    ce = '{default: 0};
    full_pre = (m_q.size() == 32);
    if (rdy) begin
      if (m_q.size() > 0 && m_q[0].ready) begin
        c  = 1;
        ce = m_q[0];
        if (ce.kind == 2'd1) begin
          redir = (ce.value[0] != ce.pred);
          cpc   = ce.value[0] ? ce.jpc : ce.pc + 32'd4;
        end else if (ce.kind == 2'd2) begin
          redir = 1;
          cpc   = ce.jpc;
        end
        e_reg = (ce.kind == 2'd0 || ce.kind == 2'd2) && ce.dest != 5'd0;
        e_st  = (ce.kind == 2'd3);
      end
      foreach (m_q[i]) begin
        if (RS_to_ROB_needchange && m_q[i].tag == int'(b2)) begin
          m_q[i].value = ROB_s_value_b2_;
          m_q[i].ready = ROB_s_ready_b2_;
          if (RS_to_ROB_needchange2) m_q[i].jpc = ROB_s_jumppc_b2_;
        end
        if (SLB_to_ROB_needchange && m_q[i].tag == int'(b4)) begin
          m_q[i].value = SLB_to_ROB_value;
          m_q[i].ready = 1'b1;
        end
      end
      if (c) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % 32;
      end
      if (redir) begin
        model_reset();
      end else if (insqueue_to_ROB_needchange && !full_pre) begin
        ment_t ne;
        ne.tag = (m_head + m_q.size()) % 32;
        ne.kind = ROB_s_kind_in; ne.dest = ROB_s_dest_in; ne.pc = ROB_s_pc_in;
        ne.jpc = ROB_s_jumppc_in; ne.pred = ROB_s_predtaken_in;
        ne.value = 32'd0; ne.ready = 1'b0;
        m_q.push_back(ne);
      end
    end
    @(posedge clk);
    #1;
    chk("alloc_pos", 32'(ROB_alloc_pos), 32'((m_head + m_q.size()) % 32));
    chk("full", 32'(ROB_full), 32'(m_q.size() == 32));
    chk("commit", 32'(ROB_to_RS_needchange), 32'(c));
    if (c) begin
      chk("b3", 32'(b3), 32'(ce.tag));
      chk("value_b3", ROB_to_RS_value_b3, ce.value);
    end
    chk("reg_we", 32'(ROB_to_reg_needchange), 32'(e_reg));
    if (e_reg) chk("reg_rd", 32'(ROB_to_reg_rd), 32'(ce.dest));
    chk("storecommit", 32'(ROB_to_SLB_storecommit), 32'(e_st));
    chk("clear_flag", 32'(Clear_flag), 32'(redir));
    if (redir) chk("clear_pc", clear_pc, cpc);
  endtask

  task automatic idle_inputs();
    rdy = 1'b1;
    insqueue_to_ROB_needchange = 1'b0; ROB_s_kind_in = 2'd0; ROB_s_dest_in = 5'd0;
    ROB_s_pc_in = 32'd0; ROB_s_jumppc_in = 32'd0; ROB_s_predtaken_in = 1'b0;
    RS_to_ROB_needchange = 1'b0; RS_to_ROB_needchange2 = 1'b0; b2 = 5'd0;
    ROB_s_value_b2_ = 32'd0; ROB_s_ready_b2_ = 1'b0; ROB_s_jumppc_b2_ = 32'd0;
    SLB_to_ROB_needchange = 1'b0; b4 = 5'd0; SLB_to_ROB_value = 32'd0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_pos"}, 32'(ROB_alloc_pos), 32'd0);
    chk({nm, "_full"}, 32'(ROB_full), 32'd0);
    chk({nm, "_commit"}, 32'(ROB_to_RS_needchange), 32'd0);
    chk({nm, "_b3"}, 32'(b3), 32'd0);
    chk({nm, "_val"}, ROB_to_RS_value_b3, 32'd0);
    chk({nm, "_reg"}, 32'(ROB_to_reg_needchange), 32'd0);
    chk({nm, "_rd"}, 32'(ROB_to_reg_rd), 32'd0);
    chk({nm, "_st"}, 32'(ROB_to_SLB_storecommit), 32'd0);
    chk({nm, "_clr"}, 32'(Clear_flag), 32'd0);
    chk({nm, "_cpc"}, clear_pc, 32'd0);
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct packed {
    logic al; logic [1:0] kind; logic [4:0] dest; logic [31:0] pc; logic [31:0] jpc; logic pred;
    logic rs_v; logic rs_v2; logic [4:0] tb2; logic [31:0] rs_val; logic [31:0] rs_jpc;
    logic slb_v; logic [4:0] tb4; logic [31:0] slb_val;
    logic [4:0] e_pos; logic e_cm; logic [4:0] e_b3; logic [31:0] e_val;
    logic e_reg; logic [4:0] e_rd; logic e_st; logic e_clr; logic [31:0] e_cpc;
  } vec_t;

  function automatic vec_t vi();
    vec_t v; v = '0; return v;
  endfunction
  function automatic vec_t va(logic [1:0] k, logic [4:0] d, logic [31:0] pc, logic [31:0] jpc, logic pr);
    vec_t v; v = '0; v.al = 1'b1; v.kind = k; v.dest = d; v.pc = pc; v.jpc = jpc; v.pred = pr; return v;
  endfunction
  function automatic vec_t vr(logic [4:0] t, logic [31:0] val, logic v2, logic [31:0] jpc);
    vec_t v; v = '0; v.rs_v = 1'b1; v.tb2 = t; v.rs_val = val; v.rs_v2 = v2; v.rs_jpc = jpc; return v;
  endfunction
  function automatic vec_t vs(logic [4:0] t, logic [31:0] val);
    vec_t v; v = '0; v.slb_v = 1'b1; v.tb4 = t; v.slb_val = val; return v;
  endfunction
  function automatic vec_t ex(vec_t vin, logic [4:0] pos, logic cm, logic [4:0] eb3, logic [31:0] val,
                              logic rg, logic [4:0] rd, logic st, logic clr, logic [31:0] cpc);
    vec_t v; v = vin; v.e_pos = pos; v.e_cm = cm; v.e_b3 = eb3; v.e_val = val;
    v.e_reg = rg; v.e_rd = rd; v.e_st = st; v.e_clr = clr; v.e_cpc = cpc; return v;
  endfunction

  vec_t tv[30];

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    tv[0]  = ex(va(2'd0, 5'd1, 32'h0, 32'h0, 1'b0), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = ex(va(2'd0, 5'd2, 32'h4, 32'h0, 1'b0), 5'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = ex(va(2'd0, 5'd3, 32'h8, 32'h0, 1'b0), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3]  = ex(vr(5'd2, 32'd5, 0, 0), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[4]  = ex(vr(5'd0, 32'd7, 0, 0), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[5]  = ex(vr(5'd1, 32'd9, 0, 0), 5'd3, 1, 5'd0, 32'd7, 1, 5'd1, 0, 0, 0);
    tv[6]  = ex(vi(), 5'd3, 1, 5'd1, 32'd9, 1, 5'd2, 0, 0, 0);
    tv[7]  = ex(vi(), 5'd3, 1, 5'd2, 32'd5, 1, 5'd3, 0, 0, 0);
    tv[8]  = ex(vi(), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[9]  = ex(va(2'd1, 5'd0, 32'h100, 32'h200, 1'b0), 5'd4, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[10] = ex(vr(5'd3, 32'd1, 0, 0), 5'd4, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[11] = ex(vi(), 5'd0, 1, 5'd3, 32'd1, 0, 0, 0, 1, 32'h200);
    tv[12] = ex(vi(), 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[13] = ex(va(2'd2, 5'd5, 32'h40, 32'h0, 1'b0), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[14] = ex(vr(5'd0, 32'h44, 1, 32'h80), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[15] = ex(vi(), 5'd0, 1, 5'd0, 32'h44, 1, 5'd5, 0, 1, 32'h80);
    tv[16] = ex(va(2'd3, 5'd0, 32'h10, 32'h0, 1'b0), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[17] = ex(vs(5'd0, 32'd0), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[18] = ex(vi(), 5'd1, 1, 5'd0, 32'd0, 0, 0, 1, 0, 0);
    tv[19] = ex(va(2'd1, 5'd0, 32'h20, 32'h30, 1'b1), 5'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[20] = ex(vr(5'd1, 32'd1, 0, 0), 5'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[21] = ex(vi(), 5'd2, 1, 5'd1, 32'd1, 0, 0, 0, 0, 0);
    tv[22] = ex(vr(5'd5, 32'd3, 0, 0), 5'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[23] = ex(vi(), 5'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[24] = ex(va(2'd1, 5'd0, 32'hFFFF_FFFC, 32'h500, 1'b1), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[25] = ex(vr(5'd2, 32'd0, 0, 0), 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[26] = ex(vi(), 5'd0, 1, 5'd2, 32'd0, 0, 0, 0, 1, 32'h0);
    tv[27] = ex(va(2'd0, 5'd0, 32'h0, 32'h0, 1'b0), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[28] = ex(vs(5'd0, 32'h11), 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[29] = ex(vi(), 5'd1, 1, 5'd0, 32'h11, 0, 0, 0, 0, 0);

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 30; i++) begin
      idle_inputs();
      insqueue_to_ROB_needchange = tv[i].al; ROB_s_kind_in = tv[i].kind;
      ROB_s_dest_in = tv[i].dest; ROB_s_pc_in = tv[i].pc; ROB_s_jumppc_in = tv[i].jpc;
      ROB_s_predtaken_in = tv[i].pred;
      RS_to_ROB_needchange = tv[i].rs_v; RS_to_ROB_needchange2 = tv[i].rs_v2; b2 = tv[i].tb2;
      ROB_s_value_b2_ = tv[i].rs_val; ROB_s_ready_b2_ = tv[i].rs_v; ROB_s_jumppc_b2_ = tv[i].rs_jpc;
      SLB_to_ROB_needchange = tv[i].slb_v; b4 = tv[i].tb4; SLB_to_ROB_value = tv[i].slb_val;
      tick();
      chk($sformatf("tv%0d_pos", i), 32'(ROB_alloc_pos), 32'(tv[i].e_pos));
      chk($sformatf("tv%0d_commit", i), 32'(ROB_to_RS_needchange), 32'(tv[i].e_cm));
      if (tv[i].e_cm) begin
        chk($sformatf("tv%0d_b3", i), 32'(b3), 32'(tv[i].e_b3));
        chk($sformatf("tv%0d_val", i), ROB_to_RS_value_b3, tv[i].e_val);
      end
      chk($sformatf("tv%0d_reg", i), 32'(ROB_to_reg_needchange), 32'(tv[i].e_reg));
      if (tv[i].e_reg) chk($sformatf("tv%0d_rd", i), 32'(ROB_to_reg_rd), 32'(tv[i].e_rd));
      chk($sformatf("tv%0d_st", i), 32'(ROB_to_SLB_storecommit), 32'(tv[i].e_st));
      chk($sformatf("tv%0d_clr", i), 32'(Clear_flag), 32'(tv[i].e_clr));
      if (tv[i].e_clr) chk($sformatf("tv%0d_cpc", i), clear_pc, tv[i].e_cpc);
    end

    // ---- full buffer: 32 allocs, a dropped 33rd, commit vs alloc at full ----
    do_reset();
    for (int i = 0; i < 32; i++) begin
      idle_inputs();
      insqueue_to_ROB_needchange = 1'b1; ROB_s_dest_in = 5'(i + 1); ROB_s_pc_in = 32'(i * 4);
      tick();
    end
    chk("full_after_32", 32'(ROB_full), 32'd1);
    chk("pos_after_32", 32'(ROB_alloc_pos), 32'd0);
    idle_inputs(); insqueue_to_ROB_needchange = 1'b1; ROB_s_dest_in = 5'd9;
    tick();
    chk("full_after_33", 32'(ROB_full), 32'd1);
    chk("pos_after_33", 32'(ROB_alloc_pos), 32'd0);
    idle_inputs(); RS_to_ROB_needchange = 1'b1; b2 = 5'd0; ROB_s_value_b2_ = 32'hABC; ROB_s_ready_b2_ = 1'b1;
    tick();
    idle_inputs(); insqueue_to_ROB_needchange = 1'b1; ROB_s_dest_in = 5'd9;
    tick();
    chk("full_commit_pulse", 32'(ROB_to_RS_needchange), 32'd1);
    chk("full_commit_val", ROB_to_RS_value_b3, 32'hABC);
    chk("full_commit_drop", 32'(ROB_full), 32'd0);
    idle_inputs(); insqueue_to_ROB_needchange = 1'b1; ROB_s_dest_in = 5'd9;
    tick();
    chk("refill_full", 32'(ROB_full), 32'd1);
    chk("refill_pos", 32'(ROB_alloc_pos), 32'd1);

    // ---- rdy freeze with a ready head ----
    idle_inputs(); RS_to_ROB_needchange = 1'b1; b2 = 5'd1; ROB_s_value_b2_ = 32'h11; ROB_s_ready_b2_ = 1'b1;
    SLB_to_ROB_needchange = 1'b1; b4 = 5'd2; SLB_to_ROB_value = 32'h22;
    tick();
    idle_inputs();
    tick();
    chk("pre_freeze_commit", 32'(ROB_to_RS_needchange), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); rdy = 1'b0; insqueue_to_ROB_needchange = 1'b1;
      tick();
      chk("freeze_no_commit", 32'(ROB_to_RS_needchange), 32'd0);
    end
    idle_inputs();
    tick();
    chk("unfreeze_b3", 32'(b3), 32'd2);
    chk("unfreeze_val", ROB_to_RS_value_b3, 32'h22);

    // ---- asynchronous reset mid-cycle ----
    idle_inputs(); insqueue_to_ROB_needchange = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- randomized run against the queue model ----
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      insqueue_to_ROB_needchange = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 15);
      ROB_s_kind_in = (r < 10) ? 2'd0 : (r < 12) ? 2'd3 : (r < 15) ? 2'd1 : 2'd2;
      ROB_s_dest_in = 5'($urandom_range(0, 31));
      ROB_s_pc_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      ROB_s_jumppc_in = $urandom;
      ROB_s_predtaken_in = 1'($urandom_range(0, 1));
      RS_to_ROB_needchange = ($urandom_range(0, 1) == 1);
      RS_to_ROB_needchange2 = ($urandom_range(0, 1) == 1);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
        b2 = 5'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
      else
        b2 = 5'($urandom_range(0, 31));
      ROB_s_value_b2_ = $urandom;
      ROB_s_ready_b2_ = ($urandom_range(0, 7) != 0);
      ROB_s_jumppc_b2_ = $urandom;
      SLB_to_ROB_needchange = ($urandom_range(0, 2) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
        b4 = 5'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
      else
        b4 = 5'($urandom_range(0, 31));
      if (RS_to_ROB_needchange && b4 == b2) SLB_to_ROB_needchange = 1'b0;
      SLB_to_ROB_value = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
